control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Clock  in  1  single clock; all state changes on rising edge.
REQ-002 Reset_n  in  1  asynchronous, active-low reset.
REQ-003 IR_Out  in  16  instruction register contents; opcode = IR_Out[15:12].
REQ-004 ALU_FlagOut  in  4  ALU flags; bit0 = Z.
REQ-005 RF_O1Sel  out  3  RF output-1 select.
REQ-006 RF_O2Sel  out  3  RF output-2 select.
REQ-007 RF_FunSel  out  2  RF function (00 clr, 01 load, 10 dec, 11 inc).
REQ-008 RF_RSel  out  4  RF R1..R4 enable; bit3 = R1.
REQ-009 RF_TSel  out  4  RF T1..T4 enable; constant 0000.
REQ-010 ALU_FunSel  out  4  ALU operation.
REQ-011 ARF_OutASel  out  2  ARF OutA select; constant 00.
REQ-012 ARF_OutBSel  out  2  ARF OutB (memory address) select; constant 11 (PC).
REQ-013 ARF_FunSel  out  2  ARF function (00 clr, 01 load, 10 inc, 11 dec).
REQ-014 ARF_RSel  out  4  ARF enable; bit3 = PC.
REQ-015 IR_LH  out  1  IR half select (0 low byte, 1 high byte).
REQ-016 IR_Enable  out  1  IR update enable.
REQ-017 IR_Funsel  out  2  IR function (00 clr, 01 load).
REQ-018 Mem_WR  out  1  memory write; constant 0.
REQ-019 Mem_CS  out  1  memory chip select, active low.
REQ-020 MuxASel  out  2  RF input mux (00 ALU, 10 IR[7:0]).
REQ-021 MuxBSel  out  2  ARF input mux (10 IR[7:0]).
REQ-022 MuxCSel  out  1  ALU A-input mux; constant 0 (RF_O1).
REQ-023 Halted  out  1  high while in HALT.

Function
REQ-024 Idle output set: all enables, RSel, IR_Enable and IR_LH = 0; Mem_CS = 1; all other selects 0 except fixed constants above.
REQ-025 States PRIME, FETCH_L, FETCH_H, DECODE, EXEC, HALT, plus 3-bit step counter E (0..4) used in EXEC. Outputs are decoded combinationally from state, E and IR_Out; any output not listed for a state takes its idle value.
REQ-026 PRIME: IR_Enable=1, IR_Funsel=00, ARF_FunSel=00, ARF_RSel=1000. Lasts 1 cycle, then FETCH_L.
REQ-027 FETCH_L and FETCH_H: Mem_CS=0, IR_Enable=1, IR_Funsel=01, ARF_FunSel=10, ARF_RSel=1000. IR_LH=0 in FETCH_L and 1 in FETCH_H. The instruction word is {mem[PC+1], mem[PC]}.
REQ-028 DECODE (1 cycle, idle outputs): go to EXEC with E=0 for LDI/ALU/BRA/INC/DEC. BEQ goes to EXEC only if ALU_FlagOut[0]=1 at this edge. HLT goes to HALT. Every other case goes to FETCH_L.
REQ-029 Destination dest = IR[9:8] (IR[7:6] for ALU); one-hot mapping 00→1000, 01→0100, 10→0010, 11→0001.
REQ-030 LDI (0x1): E0 MuxASel=10; E1 MuxASel=10, RF_FunSel=01, RF_RSel=dest.
REQ-031 ALU (0x2): E0–E4 ALU_FunSel=IR[11:8], RF_O1Sel=IR[5:3], RF_O2Sel=IR[2:0]; E3–E4 MuxASel=00; E4 RF_FunSel=01, RF_RSel=dest.
REQ-032 BRA (0x3) / BEQ (0x4): E0 MuxBSel=10; E1 MuxBSel=10, ARF_FunSel=01, ARF_RSel=1000.
REQ-033 INC (0x5) / DEC (0x6): E0 only, with RF_FunSel=11 for INC or 10 for DEC, and RF_RSel=dest.
REQ-034 After the last step, E clears and the state goes to FETCH_L. E never exceeds 4.
REQ-035 PC wraps 0xFF→0x00 naturally (ARF behaviour); the block takes no action on wrap.

Reset
REQ-036 Reset_n=0 forces state PRIME, E=0, Halted=0 and the idle output set immediately, regardless of state (including mid-EXEC).
REQ-037 The first rising edge after release executes PRIME.

Configuration
REQ-038 CU_HALT_EN defined: opcode 0xF enters HALT, which holds idle outputs with Halted=1 until reset.
REQ-039 CU_HALT_EN undefined: opcode 0xF behaves as NOP, and Halted is tied to 0.

Verification
REQ-040 Reset; RAM[0]=0x5A, RAM[1]=0x10 → cycles PRIME, FETCH_L, FETCH_H, DECODE, E0, E1. E1 drives MuxASel=10, RF_FunSel=01, RF_RSel=1000. The next state is FETCH_L.
REQ-041 IR_Out=0x24A5 → E0–E4 drive ALU_FunSel=0100, RF_O1Sel=100, RF_O2Sel=101. E4 drives RF_RSel=0010, RF_FunSel=01.
REQ-042 IR_Out=0x4020 with ALU_FlagOut=0001 at DECODE → E1 drives ARF_FunSel=01, ARF_RSel=1000, MuxBSel=10. With 0000 → DECODE goes directly to FETCH_L.
REQ-043 IR_Out=0xF000 → with CU_HALT_EN: Halted=1 and idle outputs for 100 cycles. Without CU_HALT_EN: FETCH_L follows DECODE.
REQ-044 Reset_n pulled low during E2 of 0x24A5 → RF_RSel=0000 and Mem_CS=1 without waiting for a clock edge. After release, PRIME occurs.
REQ-045 IR_Out=0x9123 → DECODE goes to FETCH_L, and no RF or ARF enable is asserted.

Source files
------------

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle control unit: fetch/decode/execute FSM with step counter; optional HALT via CU_HALT_EN
module control_unit (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [15:0] IR_Out,
    input  logic [3:0]  ALU_FlagOut,
    output logic [2:0]  RF_O1Sel,
    output logic [2:0]  RF_O2Sel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_RSel,
    output logic [3:0]  RF_TSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutASel,
    output logic [1:0]  ARF_OutBSel,
    output logic [1:0]  ARF_FunSel,
    output logic [3:0]  ARF_RSel,
    output logic        IR_LH,
    output logic        IR_Enable,
    output logic [1:0]  IR_Funsel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic        Halted
);

    typedef enum logic [2:0] {
        S_PRIME   = 3'd0,
        S_FETCH_L = 3'd1,
        S_FETCH_H = 3'd2,
        S_DECODE  = 3'd3,
        S_EXEC    = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ALU = 4'h2;
    localparam logic [3:0] OP_BRA = 4'h3;
    localparam logic [3:0] OP_BEQ = 4'h4;
    localparam logic [3:0] OP_INC = 4'h5;
    localparam logic [3:0] OP_DEC = 4'h6;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t     state_q, state_d;
    logic [2:0] e_q, e_d;
    logic [2:0] last_step;
    logic [1:0] dest_code;
    logic [3:0] dest;
    logic [3:0] opcode;
    logic       unused_flags;

    assign opcode       = IR_Out[15:12];
    assign unused_flags = ^ALU_FlagOut[3:1];
    assign dest_code    = (opcode == OP_ALU) ? IR_Out[7:6] : IR_Out[9:8];

    always_comb begin
        dest = 4'b0000;
        case (dest_code)
            2'b00: dest = 4'b1000;
            2'b01: dest = 4'b0100;
            2'b10: dest = 4'b0010;
            2'b11: dest = 4'b0001;
            default: dest = 4'b0000;
        endcase
    end

    // Index of the final EXEC step for each executable opcode.
    always_comb begin
        last_step = 3'd0;
        case (opcode)
            OP_LDI, OP_BRA, OP_BEQ: last_step = 3'd1;
            OP_ALU:                 last_step = 3'd4;
            default:                last_step = 3'd0;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_PRIME;
            e_q     <= 3'd0;
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
        end
    end

    always_comb begin
        state_d = state_q;
        e_d     = e_q;
        case (state_q)
            S_PRIME:   state_d = S_FETCH_L;
            S_FETCH_L: state_d = S_FETCH_H;
            S_FETCH_H: state_d = S_DECODE;
            S_DECODE: begin
                e_d = 3'd0;
                case (opcode)
                    OP_LDI, OP_ALU, OP_BRA, OP_INC, OP_DEC: state_d = S_EXEC;
                    OP_BEQ:  state_d = ALU_FlagOut[0] ? S_EXEC : S_FETCH_L;
`ifdef CU_HALT_EN
                    OP_HLT:  state_d = S_HALT;
`else
                    OP_HLT:  state_d = S_FETCH_L;
`endif
                    default: state_d = S_FETCH_L;
                endcase
            end
            S_EXEC: begin
                if (e_q >= last_step) begin
                    e_d     = 3'd0;
                    state_d = S_FETCH_L;
                end else begin
                    e_d = e_q + 3'd1;
                end
            end
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_PRIME;
        endcase
    end

    // Reset_n gates the decode so the idle set appears without waiting for an edge.
    always_comb begin
        RF_O1Sel    = 3'b000;
        RF_O2Sel    = 3'b000;
        RF_FunSel   = 2'b00;
        RF_RSel     = 4'b0000;
        RF_TSel     = 4'b0000;
        ALU_FunSel  = 4'b0000;
        ARF_OutASel = 2'b00;
        ARF_OutBSel = 2'b11;
        ARF_FunSel  = 2'b00;
        ARF_RSel    = 4'b0000;
        IR_LH       = 1'b0;
        IR_Enable   = 1'b0;
        IR_Funsel   = 2'b00;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 1'b0;
        Halted      = 1'b0;
        if (Reset_n) begin
            case (state_q)
                S_PRIME: begin
                    IR_Enable  = 1'b1;
                    IR_Funsel  = 2'b00;
                    ARF_FunSel = 2'b00;
                    ARF_RSel   = 4'b1000;
                end
                S_FETCH_L, S_FETCH_H: begin
                    Mem_CS     = 1'b0;
                    IR_Enable  = 1'b1;
                    IR_Funsel  = 2'b01;
                    ARF_FunSel = 2'b10;
                    ARF_RSel   = 4'b1000;
                    IR_LH      = (state_q == S_FETCH_H);
                end
                S_EXEC: begin
                    case (opcode)
                        OP_LDI: begin
                            MuxASel = 2'b10;
                            if (e_q == 3'd1) begin
                                RF_FunSel = 2'b01;
                                RF_RSel   = dest;
                            end
                        end
                        OP_ALU: begin
                            ALU_FunSel = IR_Out[11:8];
                            RF_O1Sel   = IR_Out[5:3];
                            RF_O2Sel   = IR_Out[2:0];
                            if (e_q == 3'd4) begin
                                RF_FunSel = 2'b01;
                                RF_RSel   = dest;
                            end
                        end
                        OP_BRA, OP_BEQ: begin
                            MuxBSel = 2'b10;
                            if (e_q == 3'd1) begin
                                ARF_FunSel = 2'b01;
                                ARF_RSel   = 4'b1000;
                            end
                        end
                        OP_INC: begin
                            RF_FunSel = 2'b11;
                            RF_RSel   = dest;
                        end
                        OP_DEC: begin
                            RF_FunSel = 2'b10;
                            RF_RSel   = dest;
                        end
                        default: ;
                    endcase
                end
`ifdef CU_HALT_EN
                S_HALT: Halted = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit with directed instruction vectors
module tb_control_unit;

    logic        Clock;
    logic        Reset_n;
    logic [15:0] IR_Out;
    logic [3:0]  ALU_FlagOut;
    logic [2:0]  RF_O1Sel, RF_O2Sel;
    logic [1:0]  RF_FunSel;
    logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel;
    logic [1:0]  ARF_OutASel, ARF_OutBSel, ARF_FunSel;
    logic [3:0]  ARF_RSel;
    logic        IR_LH, IR_Enable;
    logic [1:0]  IR_Funsel;
    logic        Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel, Halted;

    typedef struct packed {
        logic [2:0] o1;
        logic [2:0] o2;
        logic [1:0] rf_fun;
        logic [3:0] rf_rsel;
        logic [3:0] rf_tsel;
        logic [3:0] alu_fun;
        logic [1:0] arf_outa;
        logic [1:0] arf_outb;
        logic [1:0] arf_fun;
        logic [3:0] arf_rsel;
        logic       ir_lh;
        logic       ir_en;
        logic [1:0] ir_fun;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] mux_a;
        logic [1:0] mux_b;
        logic       mux_c;
        logic       halted;
    } outs_t;

    typedef struct {
        string name;
        outs_t v;
    } exp_t;

    exp_t  exp_q[$];
    outs_t act;
    int    vectors = 0;
    int    errors  = 0;

    control_unit dut (
        .Clock(Clock), .Reset_n(Reset_n), .IR_Out(IR_Out), .ALU_FlagOut(ALU_FlagOut),
        .RF_O1Sel(RF_O1Sel), .RF_O2Sel(RF_O2Sel), .RF_FunSel(RF_FunSel), .RF_RSel(RF_RSel),
        .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel), .ARF_OutASel(ARF_OutASel),
        .ARF_OutBSel(ARF_OutBSel), .ARF_FunSel(ARF_FunSel), .ARF_RSel(ARF_RSel),
        .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel), .Mem_WR(Mem_WR),
        .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
        .Halted(Halted)
    );

    assign act = '{RF_O1Sel, RF_O2Sel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
                   ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RSel, IR_LH, IR_Enable,
                   IR_Funsel, Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel, Halted};

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s actual=%h required=%h", e.name, act, e.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic outs_t f_idle();
        outs_t v;
        v          = '0;
        v.arf_outb = 2'b11;
        v.mem_cs   = 1'b1;
        return v;
    endfunction

    function automatic outs_t f_prime();
        outs_t v;
        v          = f_idle();
        v.ir_en    = 1'b1;
        v.arf_rsel = 4'b1000;
        return v;
    endfunction

    function automatic outs_t f_fetch(input logic lh);
        outs_t v;
        v          = f_idle();
        v.mem_cs   = 1'b0;
        v.ir_en    = 1'b1;
        v.ir_fun   = 2'b01;
        v.arf_fun  = 2'b10;
        v.arf_rsel = 4'b1000;
        v.ir_lh    = lh;
        return v;
    endfunction

    // Queue the expectation for the current cycle, then advance to just after the next edge.
    task automatic cyc(input string nm, input outs_t v);
        exp_t e;
        e.name = nm;
        e.v    = v;
        exp_q.push_back(e);
        @(posedge Clock);
        #1;
    endtask

    task automatic fetch_decode(input string tag, input logic [15:0] ir, input logic [3:0] fl);
        IR_Out      = ir;
        ALU_FlagOut = fl;
        cyc({tag, "_fetch_l"}, f_fetch(1'b0));
        cyc({tag, "_fetch_h"}, f_fetch(1'b1));
        cyc({tag, "_decode"},  f_idle());
    endtask

    outs_t v;

    initial begin
        Reset_n     = 1'b0;
        IR_Out      = 16'h0000;
        ALU_FlagOut = 4'h0;
        @(posedge Clock);
        #1;
        cyc("reset_idle", f_idle());
        Reset_n = 1'b1;
        cyc("prime", f_prime());

        // LDI 0x105A: dest R1
        fetch_decode("ldi", 16'h105A, 4'h0);
        v = f_idle(); v.mux_a = 2'b10;
        cyc("ldi_e0", v);
        v.rf_fun = 2'b01; v.rf_rsel = 4'b1000;
        cyc("ldi_e1", v);

        // ALU 0x24A5: fun 0100, O1=100, O2=101, dest R3
        fetch_decode("alu", 16'h24A5, 4'h0);
        v = f_idle(); v.alu_fun = 4'b0100; v.o1 = 3'b100; v.o2 = 3'b101;
        cyc("alu_e0", v);
        cyc("alu_e1", v);
        cyc("alu_e2", v);
        cyc("alu_e3", v);
        v.rf_fun = 2'b01; v.rf_rsel = 4'b0010;
        cyc("alu_e4", v);

        // BEQ taken
        fetch_decode("beq_t", 16'h4020, 4'b0001);
        v = f_idle(); v.mux_b = 2'b10;
        cyc("beq_t_e0", v);
        v.arf_fun = 2'b01; v.arf_rsel = 4'b1000;
        cyc("beq_t_e1", v);

        // BEQ not taken: DECODE falls straight into the next fetch
        fetch_decode("beq_n", 16'h4020, 4'b0000);

        // BRA
        fetch_decode("bra", 16'h3007, 4'h0);
        v = f_idle(); v.mux_b = 2'b10;
        cyc("bra_e0", v);
        v.arf_fun = 2'b01; v.arf_rsel = 4'b1000;
        cyc("bra_e1", v);

        // INC dest R4, DEC dest R2
        fetch_decode("inc", 16'h5300, 4'h0);
        v = f_idle(); v.rf_fun = 2'b11; v.rf_rsel = 4'b0001;
        cyc("inc_e0", v);
        fetch_decode("dec", 16'h6100, 4'h0);
        v = f_idle(); v.rf_fun = 2'b10; v.rf_rsel = 4'b0100;
        cyc("dec_e0", v);

        // Undefined opcode acts as a no-op
        fetch_decode("nop", 16'h9123, 4'h0);

        // Reset asserted during E2 of an ALU op
        fetch_decode("alur", 16'h24A5, 4'h0);
        v = f_idle(); v.alu_fun = 4'b0100; v.o1 = 3'b100; v.o2 = 3'b101;
        cyc("alur_e0", v);
        cyc("alur_e1", v);
        Reset_n = 1'b0;
        cyc("alur_rst_e2", f_idle());
        Reset_n = 1'b1;
        cyc("alur_prime", f_prime());

        // Halt opcode
        fetch_decode("hlt", 16'hF000, 4'h0);
`ifdef CU_HALT_EN
        v = f_idle(); v.halted = 1'b1;
        for (int i = 0; i < 100; i++) cyc("hlt_hold", v);
`else
        cyc("hlt_nop_fetch_l", f_fetch(1'b0));
`endif

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clock);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
